// File: rtl/stack_pkg.sv
// Shared types and sizing for the return-stack sequencer.
// Requester IDs double as the RetDst encoding.
package stack_pkg;
  localparam int DATA_W = 12;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    PUSH,
    POP,
    POP_WAIT,
    RET
  } state_t;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_INT  = 1'b1;
endpackage

// File: rtl/stack_if.sv
// Request, return and stack-side signals of the stack sequencer.
// slave is the sequencer side, master the surrounding logic.
interface stack_if;
  import stack_pkg::*;

  logic              CallReq;
  logic [DATA_W-1:0] CallAddr;
  logic              RetReq;
  logic              CoreGnt;
  logic              IntReq;
  logic [DATA_W-1:0] IntAddr;
  logic              RetfieReq;
  logic              IntGnt;
  logic [DATA_W-1:0] RetAddr;
  logic              RetValid;
  logic              RetDst;
  logic              StkPushEnbl;
  logic              StkPopEnbl;
  logic [DATA_W-1:0] StkPushData;
  logic [DATA_W-1:0] StkPopData;
  logic              StkFull;
  logic [CNT_W-1:0]  Count;
  logic              Busy;
  logic              Overflow;
  logic              Underflow;
  logic              ErrClr;

  modport slave (
    input  CallReq, CallAddr, RetReq,
    input  IntReq, IntAddr, RetfieReq,
    input  StkPopData, StkFull, ErrClr,
    output CoreGnt, IntGnt,
    output RetAddr, RetValid, RetDst,
    output StkPushEnbl, StkPopEnbl, StkPushData,
    output Count, Busy, Overflow, Underflow
  );

  modport master (
    output CallReq, CallAddr, RetReq,
    output IntReq, IntAddr, RetfieReq,
    output StkPopData, StkFull, ErrClr,
    input  CoreGnt, IntGnt,
    input  RetAddr, RetValid, RetDst,
    input  StkPushEnbl, StkPopEnbl, StkPushData,
    input  Count, Busy, Overflow, Underflow
  );
endinterface

// File: rtl/stack_arb.sv
// Fixed-priority arbiter: interrupt over core,
// push over pop within a requester.
module stack_arb
  import stack_pkg::*;
(
  input  logic call_req,
  input  logic ret_req,
  input  logic int_req,
  input  logic retfie_req,
  output logic valid,
  output logic id,
  output logic push
);
  logic int_any;
  logic core_any;

  assign int_any  = int_req | retfie_req;
  assign core_any = call_req | ret_req;

  assign valid = int_any | core_any;
  assign id    = int_any ? REQ_INT : REQ_CORE;
  assign push  = int_any ? int_req : call_req;
endmodule

// File: rtl/stack_ctrl.sv
// Return-stack sequencer: arbitrates push/pop commands, drives
// the stack enables, captures popped addresses, tracks occupancy.
module stack_ctrl
  import stack_pkg::*;
(
  input  logic Clk,
  input  logic Reset,
  stack_if.slave bus
);
  state_t state_q, state_d;

  logic              arb_valid, arb_id, arb_push;
  logic              full;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, unf_q, ovf_set, unf_set;
  logic              owner_q, owner_d;
  logic              pop_ok_q, pop_ok_d;
  logic              core_gnt_q, core_gnt_d;
  logic              int_gnt_q, int_gnt_d;
  logic              push_en_q, push_en_d;
  logic              pop_en_q, pop_en_d;
  logic [DATA_W-1:0] push_data_q, push_data_d;
  logic [DATA_W-1:0] ret_addr_q, ret_addr_d;
  logic              ret_valid_q, ret_valid_d;
  logic              ret_dst_q, ret_dst_d;
  logic              busy_q, busy_d;

  stack_arb u_arb (
    .call_req   (bus.CallReq),
    .ret_req    (bus.RetReq),
    .int_req    (bus.IntReq),
    .retfie_req (bus.RetfieReq),
    .valid      (arb_valid),
    .id         (arb_id),
    .push       (arb_push)
  );

  assign full = (cnt_q == CNT_W'(DEPTH)) || bus.StkFull;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ovf_set     = 1'b0;
    unf_set     = 1'b0;
    owner_d     = owner_q;
    pop_ok_d    = pop_ok_q;
    core_gnt_d  = 1'b0;
    int_gnt_d   = 1'b0;
    push_en_d   = 1'b0;
    pop_en_d    = 1'b0;
    push_data_d = push_data_q;
    ret_addr_d  = ret_addr_q;
    ret_valid_d = 1'b0;
    ret_dst_d   = ret_dst_q;
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          owner_d    = arb_id;
          core_gnt_d = (arb_id == REQ_CORE);
          int_gnt_d  = (arb_id == REQ_INT);
          if (arb_push) begin
            state_d     = PUSH;
            push_en_d   = !full;
            push_data_d = arb_id ? bus.IntAddr : bus.CallAddr;
          end else begin
            state_d  = POP;
            pop_ok_d = (cnt_q != '0);
            pop_en_d = (cnt_q != '0);
          end
        end
      end
      PUSH: begin
        state_d = IDLE;
        if (push_en_q) cnt_d = cnt_q + CNT_W'(1);
        else           ovf_set = 1'b1;
      end
      POP: begin
        state_d = POP_WAIT;
        if (pop_en_q) cnt_d = cnt_q - CNT_W'(1);
        else          unf_set = 1'b1;
      end
      POP_WAIT: begin
        state_d     = RET;
        ret_valid_d = 1'b1;
        ret_dst_d   = owner_q;
        ret_addr_d  = pop_ok_q ? bus.StkPopData : '0;
      end
      RET:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      owner_q     <= REQ_CORE;
      pop_ok_q    <= 1'b0;
      core_gnt_q  <= 1'b0;
      int_gnt_q   <= 1'b0;
      push_en_q   <= 1'b0;
      pop_en_q    <= 1'b0;
      push_data_q <= '0;
      ret_addr_q  <= '0;
      ret_valid_q <= 1'b0;
      ret_dst_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      // A new error wins over a simultaneous clear
      ovf_q       <= ovf_set | (ovf_q & ~bus.ErrClr);
      unf_q       <= unf_set | (unf_q & ~bus.ErrClr);
      owner_q     <= owner_d;
      pop_ok_q    <= pop_ok_d;
      core_gnt_q  <= core_gnt_d;
      int_gnt_q   <= int_gnt_d;
      push_en_q   <= push_en_d;
      pop_en_q    <= pop_en_d;
      push_data_q <= push_data_d;
      ret_addr_q  <= ret_addr_d;
      ret_valid_q <= ret_valid_d;
      ret_dst_q   <= ret_dst_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.CoreGnt     = core_gnt_q;
  assign bus.IntGnt      = int_gnt_q;
  assign bus.StkPushEnbl = push_en_q;
  assign bus.StkPopEnbl  = pop_en_q;
  assign bus.StkPushData = push_data_q;
  assign bus.RetAddr     = ret_addr_q;
  assign bus.RetValid    = ret_valid_q;
  assign bus.RetDst      = ret_dst_q;
  assign bus.Count       = cnt_q;
  assign bus.Busy        = busy_q;
  assign bus.Overflow    = ovf_q;
  assign bus.Underflow   = unf_q;
endmodule
